// File: rtl/alu_operand_sequencer_if.sv
// Operand-entry bus between the switch/button front end, the sequencer and the result-capture stage.
// master = sequencer side; slave = the environment driving buttons and consuming the operation.
interface alu_operand_sequencer_if;
    logic       clear;
    logic       enter;
    logic [3:0] data_in;
    logic       out_ready;
    logic [7:0] z;
    logic [1:0] select;
    logic       out_valid;
    logic [1:0] state;
    logic [7:0] op_count;

    modport master (
        input  clear, enter, data_in, out_ready,
        output z, select, out_valid, state, op_count
    );

    modport slave (
        output clear, enter, data_in, out_ready,
        input  z, select, out_valid, state, op_count
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects x, y and opcode from a switch bank (one enter press each); out_valid rises 1 cycle after the opcode press.
// Holds z/select/out_valid until out_ready is seen; optional enter debounce under `DEBOUNCE_EN.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    alu_operand_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_X    = 2'b00,
        S_Y    = 2'b01,
        S_OP   = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] z_q, z_d;
    logic [1:0] select_q, select_d;
    logic       valid_q;
    logic [7:0] count_q, count_d;
    logic       press;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce_cycles
        $error("DEBOUNCE_CYCLES must lie in 2..255");
    end

`ifdef DEBOUNCE_EN
    localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES);
    logic [7:0] deb_cnt;

    // Saturating run-length of enter; a press fires only on the step into saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt <= 8'h00;
        end else if (bus.clear || !bus.enter) begin
            deb_cnt <= 8'h00;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + 8'h01;
        end
    end

    assign press = bus.enter && (deb_cnt == DEB_MAX - 8'h01);
`else
    logic enter_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q <= 1'b0;
        end else begin
            enter_q <= bus.enter;
        end
    end

    assign press = bus.enter && !enter_q;
`endif

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        select_d = select_q;
        count_d  = count_q;
        if (bus.clear) begin
            state_d = S_X;
        end else begin
            unique case (state_q)
                S_X: begin
                    if (press) begin
                        z_d[3:0] = bus.data_in;
                        state_d  = S_Y;
                    end
                end
                S_Y: begin
                    if (press) begin
                        z_d[7:4] = bus.data_in;
                        state_d  = S_OP;
                    end
                end
                S_OP: begin
                    if (press) begin
                        select_d = bus.data_in[1:0];
                        state_d  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Presses are dropped here; only the handshake leaves this state.
                    if (valid_q && bus.out_ready) begin
                        count_d = count_q + 8'h01;
                        state_d = S_X;
                    end
                end
                default: state_d = S_X;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_X;
            z_q      <= 8'h00;
            select_q <= 2'b00;
            valid_q  <= 1'b0;
            count_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            select_q <= select_d;
            valid_q  <= (state_d == S_HOLD);
            count_q  <= count_d;
        end
    end

    assign bus.z         = z_q;
    assign bus.select    = select_q;
    assign bus.out_valid = valid_q;
    assign bus.state     = state_q;
    assign bus.op_count  = count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a field-index reference model checked every negedge.
module tb_alu_operand_sequencer;
    localparam int DC = 4;
`ifdef DEBOUNCE_EN
    localparam int PH = DC;
`else
    localparam int PH = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    alu_operand_sequencer_if bus();

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which field is next (0=x,1=y,2=op,3=waiting), plus captured values.
    int         m_field = 0;
    logic [3:0] m_x = 0, m_y = 0;
    logic [1:0] m_sel = 0;
    int         m_cnt = 0;
    logic       m_prev = 0;
    int         m_run = 0;

    always @(posedge clk or posedge reset) begin
        logic p;
        if (reset) begin
            m_field = 0; m_x = 0; m_y = 0; m_sel = 0; m_cnt = 0; m_prev = 0; m_run = 0;
        end else begin
`ifdef DEBOUNCE_EN
            p     = bus.enter && (m_run + 1 == DC);
            m_run = (bus.clear || !bus.enter) ? 0 : m_run + 1;
`else
            p      = bus.enter && !m_prev;
            m_prev = bus.enter;
`endif
            if (bus.clear) begin
                m_field = 0;
            end else if (m_field == 3) begin
                if (bus.out_ready) begin
                    m_cnt   = (m_cnt + 1) % 256;
                    m_field = 0;
                end
            end else if (p) begin
                if (m_field == 0) m_x = bus.data_in;
                else if (m_field == 1) m_y = bus.data_in;
                else m_sel = bus.data_in[1:0];
                m_field = m_field + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_z", bus.z, {m_y, m_x});
        chk("model_select", bus.select, m_sel);
        chk("model_valid", bus.out_valid, m_field == 3);
        chk("model_state", bus.state, m_field[1:0]);
        chk("model_count", bus.op_count, m_cnt[7:0]);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.data_in = d;
        bus.enter   = 1'b1;
        step(PH);
        bus.enter   = 1'b0;
        step(1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.clear = 0; bus.enter = 0; bus.data_in = 0; bus.out_ready = 0;
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_state", bus.state, 2'b00);
        chk("rst_z", bus.z, 8'h00);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_count", bus.op_count, 8'h00);

        // Basic operation with out_valid latency check on the opcode press
        press(4'hA);
        press(4'h5);
        bus.data_in = 4'h2;
        bus.enter   = 1'b1;
        step(PH - 1);
        chk("pre_valid", bus.out_valid, 1'b0);
        step(1);
        chk("valid_lat", bus.out_valid, 1'b1);
        chk("hold_state", bus.state, 2'b11);
        bus.enter = 1'b0;
        step(1);
        chk("basic_z", bus.z, 8'h5A);
        chk("basic_sel", bus.select, 2'b10);

        // Presses in HOLD are ignored; valid held while ready is low
        press(4'hF);
        chk("ign_z", bus.z, 8'h5A);
        chk("ign_sel", bus.select, 2'b10);
        step(10);
        chk("held_valid", bus.out_valid, 1'b1);
        handshake();
        chk("hs_valid", bus.out_valid, 1'b0);
        chk("hs_state", bus.state, 2'b00);
        chk("hs_count", bus.op_count, 8'h01);
        chk("hs_z", bus.z, 8'h5A);

        // Clear with a coincident press mid-sequence
        press(4'hA);
        press(4'h5);
        bus.data_in = 4'h7;
        bus.enter   = 1'b1;
        step(PH - 1);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        step(1);
        chk("clr_state", bus.state, 2'b00);
        chk("clr_valid", bus.out_valid, 1'b0);
        chk("clr_z", bus.z, 8'h5A);

        // Held enter captures once; clear in HOLD with ready does not count
        bus.data_in = 4'h9;
        bus.enter   = 1'b1;
        step(20);
        bus.enter = 1'b0;
        step(1);
        chk("held_state", bus.state, 2'b01);
        chk("held_z", bus.z, 8'h59);
        press(4'h1);
        press(4'h3);
        chk("hold2_state", bus.state, 2'b11);
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        step(1);
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        chk("clrhold_state", bus.state, 2'b00);
        chk("clrhold_count", bus.op_count, 8'h01);

        // out_ready high during entry has no effect until HOLD
        bus.out_ready = 1'b1;
        press(4'h6);
        press(4'h7);
        chk("rdy_entry_state", bus.state, 2'b10);
        chk("rdy_entry_count", bus.op_count, 8'h01);
        press(4'h1);
        bus.out_ready = 1'b0;
        chk("rdy_entry_done", bus.op_count, 8'h02);

        // Counter wrap
        for (int i = 0; i < 253; i++) begin
            press(4'(i)); press(4'(i + 3)); press(4'(i + 1));
            handshake();
        end
        chk("count_ff", bus.op_count, 8'hFF);
        press(4'h4); press(4'h8); press(4'h3);
        handshake();
        chk("count_wrap", bus.op_count, 8'h00);
        chk("wrap_z", bus.z, 8'h84);

        // Async reset between edges while in S_OP
        press(4'hC);
        press(4'hD);
        chk("pre_rst_state", bus.state, 2'b10);
        #2 reset = 1'b1;
        #1;
        chk("arst_z", bus.z, 8'h00);
        chk("arst_sel", bus.select, 2'b00);
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_state", bus.state, 2'b00);
        step(2);
        reset = 1'b0;
        step(1);
        press(4'h1); press(4'h2); press(4'h3);
        chk("post_rst_z", bus.z, 8'h21);
        chk("post_rst_valid", bus.out_valid, 1'b1);
        handshake();
        chk("post_rst_count", bus.op_count, 8'h01);

`ifdef DEBOUNCE_EN
        bus.data_in = 4'hE;
        bus.enter   = 1'b1;
        step(DC - 1);
        bus.enter = 1'b0;
        step(1);
        chk("deb_glitch", bus.state, 2'b00);
        bus.enter = 1'b1;
        step(DC - 1);
        chk("deb_pre4", bus.state, 2'b00);
        step(1);
        chk("deb_at4", bus.state, 2'b01);
        chk("deb_x", bus.z[3:0], 4'hE);
        bus.enter = 1'b0;
        step(1);
        bus.data_in = 4'hC;
        bus.enter   = 1'b1;
        step(50);
        bus.enter = 1'b0;
        step(1);
        chk("deb_held50", bus.state, 2'b10);
        chk("deb_y", bus.z, 8'hCE);
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
